// File: rtl/frame_egress_ctrl_pkg.sv
// Shared definitions for the frame egress path.
//   - AXIS_DEST_WIDTH : default destination field width on the output stream
//   - SB_WIDTH        : sideband FIFO word width
//   - SB_DEST_LSB     : bit offset of dest in the sideband word
//   - sb_ptr_lsb()    : bit offset of the start pointer (directly above dest)
//   - axis_beat_t     : one output beat as stored in the skid buffer
package frame_egress_ctrl_pkg;

  localparam int AXIS_DEST_WIDTH = 4;
  localparam int SB_WIDTH        = 20;
  localparam int SB_DEST_LSB     = 0;

  function automatic int sb_ptr_lsb(input int dest_w);
    return SB_DEST_LSB + dest_w;
  endfunction

  typedef struct packed {
    logic       tlast;
    logic       tuser;
    logic [7:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output FIFO in front of the AXI-stream master.
//   clk, reset   : clock, async active-high reset
//   push_i/din_i : write one beat (caller guarantees room)
//   pop_i        : consume the head beat (ignored when empty)
//   dout_o       : head beat, stable until popped
//   valid_o      : buffer non-empty
//   count_o      : occupancy 0..2
module axis_skid_buffer
  import frame_egress_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  axis_beat_t din_i,
  input  logic       pop_i,
  output axis_beat_t dout_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  axis_beat_t mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] count_q;
  logic       pop;

  assign pop     = pop_i & (count_q != 2'd0);
  assign dout_o  = mem_q[rd_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_q + 2'(push_i) - 2'(pop);
    end
  end

endmodule

// File: rtl/frame_egress_ctrl.sv
// Frame egress controller: pops one sideband entry per frame, replays the
// frame's bytes from the frame buffer onto an AXI-stream master with tdest,
// then commits the frame-buffer read pointer.
//   clk, reset         : clock, async active-high reset
//   sb_ren/sb_empty    : sideband FIFO pop / empty
//   sb_rdata           : {0.., start_ptr, dest}, valid the cycle after sb_ren
//   fb_ren/fb_raddr    : frame-buffer read request (address carries wrap bit)
//   fb_rdata           : {tlast, byte}, valid the cycle after fb_ren
//   fb_rptr            : committed read pointer for the buffer writer
//   m_t*               : AXI-stream master; tuser marks a truncated frame
module frame_egress_ctrl
  import frame_egress_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DEST_WIDTH    = AXIS_DEST_WIDTH,
  parameter int MAX_FRAME_LEN = 1536
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  sb_ren,
  input  logic                  sb_empty,
  input  logic [SB_WIDTH-1:0]   sb_rdata,
  output logic                  fb_ren,
  output logic [ADDR_WIDTH:0]   fb_raddr,
  input  logic [8:0]            fb_rdata,
  output logic [ADDR_WIDTH:0]   fb_rptr,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic [7:0]            m_tdata,
  output logic [DEST_WIDTH-1:0] m_tdest
);

  localparam int AW1     = ADDR_WIDTH + 1;
  localparam int PTR_LSB = sb_ptr_lsb(DEST_WIDTH);
  localparam int LW      = $clog2(MAX_FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_STREAM, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [AW1-1:0]        raddr_q, rptr_q;
  logic [LW-1:0]         len_q;
  logic                  inflight_q;

  logic       ret, ret_last, guard_hit, frame_end, drain_done, issue, pop;
  logic [1:0] occ_sum, count;
  axis_beat_t head, din;

  logic unused_sb_hi;
  assign unused_sb_hi = ^sb_rdata[SB_WIDTH-1:PTR_LSB+AW1];

  // A read issued last cycle returns now; inflight is at most one, so the
  // returning word is always the len_q-th byte of the frame.
  assign ret        = inflight_q;
  assign ret_last   = ret & fb_rdata[8];
  assign guard_hit  = ret & ~fb_rdata[8] & (len_q == LW'(MAX_FRAME_LEN));
  assign frame_end  = ret_last | guard_hit;
  assign drain_done = (count == 2'd0) & ~inflight_q;
  assign pop        = m_tvalid & m_tready;

  // A head popping this cycle frees its slot, which keeps 1 byte/cycle.
  assign occ_sum = 2'(inflight_q) + count - 2'(pop);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (~sb_empty) state_d = S_POP;
      S_POP:    state_d = S_STREAM;
      S_STREAM: if (frame_end) state_d = S_DRAIN;
      S_DRAIN:  if (drain_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs; sb_ren is masked while reset is held so it reads 0 in reset.
  always_comb begin
    sb_ren = (state_q == S_IDLE) & ~sb_empty & ~reset;
    issue  = (state_q == S_STREAM) & ~frame_end &
             (len_q < LW'(MAX_FRAME_LEN)) & (occ_sum < 2'd2);
    fb_ren = issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q     <= '0;
      raddr_q    <= '0;
      rptr_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (state_q == S_POP) begin
        dest_q  <= sb_rdata[SB_DEST_LSB +: DEST_WIDTH];
        raddr_q <= sb_rdata[PTR_LSB +: AW1];
        len_q   <= '0;
      end else if (issue) begin
        raddr_q <= raddr_q + AW1'(1);
        len_q   <= len_q + LW'(1);
      end
      // raddr is one past the last byte read; every byte is already accepted.
      if (state_q == S_DRAIN && drain_done) rptr_q <= raddr_q;
    end
  end

  assign din = '{tlast: fb_rdata[8] | guard_hit, tuser: guard_hit,
                 tdata: fb_rdata[7:0]};

  axis_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ret),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .valid_o (m_tvalid),
    .count_o (count)
  );

  assign fb_raddr = raddr_q;
  assign fb_rptr  = rptr_q;
  assign m_tdata  = head.tdata;
  assign m_tlast  = head.tlast;
  assign m_tuser  = head.tuser;
  assign m_tdest  = dest_q;

endmodule

// File: tb/tb_frame_egress_ctrl.sv
module tb_frame_egress_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sb_ren, sb_empty;
  logic [19:0] sb_rdata = '0;
  logic        fb_ren;
  logic [11:0] fb_raddr, fb_rptr;
  logic [8:0]  fb_rdata = '0;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [7:0]  m_tdata;
  logic [3:0]  m_tdest;

  always #5 clk = ~clk;

  frame_egress_ctrl #(.ADDR_WIDTH(11), .DEST_WIDTH(4), .MAX_FRAME_LEN(8)) dut (
    .clk(clk), .reset(reset), .sb_ren(sb_ren), .sb_empty(sb_empty),
    .sb_rdata(sb_rdata), .fb_ren(fb_ren), .fb_raddr(fb_raddr),
    .fb_rdata(fb_rdata), .fb_rptr(fb_rptr), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tdata(m_tdata), .m_tdest(m_tdest)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- sideband FIFO model (read latency 1) ----------------
  logic [19:0] sbmem [16];
  int sb_wr = 0;
  int sb_rd = 0;
  assign sb_empty = (sb_rd == sb_wr);
  always @(posedge clk)
    if (sb_ren && sb_rd != sb_wr) begin
      sb_rdata <= sbmem[sb_rd % 16];
      sb_rd    <= sb_rd + 1;
    end

  // ---------------- frame buffer model (read latency 1) ----------------
  logic [8:0]  fbmem [4096];
  logic [11:0] rd_log [$];
  always @(posedge clk)
    if (fb_ren) begin
      fb_rdata <= fbmem[fb_raddr];
      rd_log.push_back(fb_raddr);
    end

  // ---------------- ready driver ----------------
  bit       tmode = 1'b0;
  logic [3:0] pat = 4'b1001;  // 1,0,0,1 repeating
  int       rcyc = 0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = tmode ? pat[rcyc % 4] : 1'b1;
      rcyc++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        user;
    logic [3:0]  dest;
    logic [11:0] rnow;   // committed pointer while this beat is on the bus
    logic [11:0] rend;   // committed pointer after its frame
  } beat_t;
  beat_t exp_q [$];
  logic [11:0] cur_rptr = '0;

  int          acc_cnt = 0;
  bit          hold = 0;
  logic [13:0] held;
  logic [11:0] last_rptr = '0;
  logic        last_acc_last = 1'b0;
  logic [11:0] last_acc_end = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      hold = 0;
      last_acc_last = 1'b0;
    end else begin
      if (hold)
        chk("stall_hold", {m_tvalid, m_tdata, m_tlast, m_tuser, m_tdest}, {1'b1, held});
      hold = m_tvalid & ~m_tready;
      held = {m_tdata, m_tlast, m_tuser, m_tdest};
      if (fb_rptr !== last_rptr) begin
        chk("rptr_after_last_beat", 32'(last_acc_last), 32'd1);
        chk("rptr_value", fb_rptr, last_acc_end);
      end
      if (m_tvalid && m_tready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat got data %0h want none", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.data);
          chk("beat_tlast", m_tlast, e.last);
          chk("beat_tuser", m_tuser, e.user);
          chk("beat_tdest", m_tdest, e.dest);
          chk("beat_rptr_held", fb_rptr, e.rnow);
          last_acc_last = e.last;
          last_acc_end  = e.rend;
        end
      end
    end
    last_rptr = fb_rptr;
  end

  // Fill frame memory, queue expected beats, push the sideband entry.
  // tl=0 rows have n == MAX_FRAME_LEN, so the guard forces tlast/tuser.
  task automatic push_frame(input logic [11:0] ptr, input logic [3:0] dest, input int n,
                            input bit tl, input logic [7:0] base, input logic [11:0] rend);
    beat_t b;
    for (int i = 0; i < n + 4; i++) begin
      logic [11:0] a;
      a = ptr + 12'(i);
      if (i < n) fbmem[a] = {tl && (i == n - 1), base + 8'(i)};
      else       fbmem[a] = {1'b0, 8'hEE};
    end
    for (int i = 0; i < n; i++) begin
      b.data = base + 8'(i);
      b.last = (i == n - 1);
      b.user = !tl && (i == n - 1);
      b.dest = dest;
      b.rnow = cur_rptr;
      b.rend = rend;
      exp_q.push_back(b);
    end
    sbmem[sb_wr % 16] = {4'b0, ptr, dest};
    sb_wr++;
    cur_rptr = rend;
  endtask

  task automatic wait_done(input string nm, input logic [11:0] exp_rptr, input int exp_reads,
                           input int rd_base);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fb_rptr !== exp_rptr) && t < 400) begin
      @(posedge clk); t++;
    end
    if (t >= 400) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d beats pending want 0", nm, exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_rptr"}, fb_rptr, exp_rptr);
    chk({nm, "_reads"}, rd_log.size() - rd_base, exp_reads);
    chk({nm, "_idle_tvalid"}, m_tvalid, 1'b0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_sb_ren"}, sb_ren, 1'b0);
    chk({nm, "_fb_ren"}, fb_ren, 1'b0);
    chk({nm, "_fb_raddr"}, fb_raddr, 12'h0);
    chk({nm, "_fb_rptr"}, fb_rptr, 12'h0);
    chk({nm, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({nm, "_m_tlast"}, m_tlast, 1'b0);
    chk({nm, "_m_tuser"}, m_tuser, 1'b0);
    chk({nm, "_m_tdata"}, m_tdata, 8'h0);
    chk({nm, "_m_tdest"}, m_tdest, 4'h0);
  endtask

  typedef struct {
    string       nm;
    logic [11:0] ptr;
    logic [3:0]  dest;
    int          n;
    bit          tl;
    logic [7:0]  base;
    bit          toggle;
    logic [11:0] rend;
  } vec_t;
  vec_t vecs [4];

  initial begin
    int rb, t, target;
    vecs[0] = '{"basic",  12'h010, 4'd2, 4, 1'b1, 8'hA0, 1'b0, 12'h014};
    vecs[1] = '{"stall",  12'h010, 4'd2, 4, 1'b1, 8'hA0, 1'b1, 12'h014};
    vecs[2] = '{"wrap",   12'h7FE, 4'd5, 4, 1'b1, 8'h70, 1'b0, 12'h802};
    vecs[3] = '{"guard",  12'h100, 4'd3, 8, 1'b0, 8'h30, 1'b0, 12'h108};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("post_rst");

    for (int v = 0; v < 4; v++) begin
      tmode = vecs[v].toggle;
      rb = rd_log.size();
      push_frame(vecs[v].ptr, vecs[v].dest, vecs[v].n, vecs[v].tl, vecs[v].base, vecs[v].rend);
      if (v == 0) begin
        // sb_empty just fell: valid must appear exactly 4 cycles later
        repeat (3) @(posedge clk);
        #1 chk("latency_c3", m_tvalid, 1'b0);
        @(posedge clk);
        #1 chk("latency_c4", m_tvalid, 1'b1);
      end
      wait_done(vecs[v].nm, vecs[v].rend, vecs[v].n, rb);
      if (vecs[v].ptr == 12'h7FE && rd_log.size() - rb >= 4)
        for (int k = 0; k < 4; k++)
          chk("wrap_addr", rd_log[rb + k], 12'h7FE + 12'(k));
    end
    tmode = 1'b0;

    // Back-to-back entries: frame 2 beats expect rptr already at 0x021.
    rb = rd_log.size();
    push_frame(12'h020, 4'd1, 1, 1'b1, 8'h50, 12'h021);
    push_frame(12'h030, 4'd6, 3, 1'b1, 8'h60, 12'h033);
    wait_done("b2b", 12'h033, 4, rb);

    // Reset during beat 2 of a 4-byte frame.
    target = acc_cnt + 2;
    push_frame(12'h040, 4'd7, 4, 1'b1, 8'hC0, 12'h044);
    t = 0;
    while (acc_cnt < target && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL midrst_timeout got %0d beats want %0d", acc_cnt, target);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cur_rptr = 12'h000;
    @(posedge clk); #1;

    rb = rd_log.size();
    push_frame(12'h050, 4'd4, 2, 1'b1, 8'hD0, 12'h052);
    wait_done("post_rst_frame", 12'h052, 2, rb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_egress_ctrl.md
# frame_egress_ctrl

Downstream consumer of the sideband FIFO. Pops one sideband entry per accepted frame, holding the destination and the frame-buffer start pointer. Replays that frame's bytes from the frame buffer onto an AXI-stream master with `tdest` attached, then advances the committed frame-buffer read pointer so the writer can reclaim the space. Sits between the sideband/frame buffers and the switch output crossbar.

## Interface
Parameters:
- `ADDR_WIDTH`, default 11: frame-buffer address width; pointers carry one extra wrap bit.
- `DEST_WIDTH`, default `` `AXIS_DEST_WIDTH ``: destination field width.
- `MAX_FRAME_LEN`, default 1536: longest legal frame in bytes; guards against a missing `tlast`.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `sb_ren`, out, 1: sideband FIFO pop.
- `sb_empty`, in, 1: sideband FIFO empty.
- `sb_rdata`, in, 20: sideband word. `[DEST_WIDTH-1:0]` is dest, `[ADDR_WIDTH+DEST_WIDTH:DEST_WIDTH]` is the start pointer, upper bits are zero.
- `fb_ren`, out, 1: frame-buffer read enable.
- `fb_raddr`, out, ADDR_WIDTH+1: frame-buffer read address, including the wrap bit.
- `fb_rdata`, in, 9: `{tlast, byte}`, valid the cycle after `fb_ren`.
- `fb_rptr`, out, ADDR_WIDTH+1: committed read pointer, seen by the frame-buffer writer for its full calculation.
- `m_tvalid`, `m_tready`, `m_tlast`, `m_tuser`, 1 each: AXI-stream master handshake. `m_tuser=1` marks a truncated or error frame.
- `m_tdata`, out, 8: output byte.
- `m_tdest`, out, DEST_WIDTH: output destination.

## Operation
State machine:
- IDLE: if `~sb_empty`, assert `sb_ren` for one cycle and go to POP.
- POP: `sb_rdata` is valid this cycle (FIFO read latency is 1). Latch `dest`, set `raddr` to the start pointer, clear `len`, go to STREAM.
- STREAM: issue reads while `inflight + occupancy < 2`.
  - `inflight` is 0 or 1.
  - `occupancy` counts the 2-entry output skid buffer.
  - Each read increments `raddr`, wrapping naturally modulo 2^(ADDR_WIDTH+1).
  - Each returning word is pushed into the skid buffer.
- Frame end: when the returning word has `tlast=1`, stop issuing reads; go to DRAIN.
- Length guard: if `len` reaches `MAX_FRAME_LEN` without `tlast`, stop issuing reads. Force `m_tlast=1` and `m_tuser=1` on the word pushed at that point; go to DRAIN.
- DRAIN: wait until the skid buffer is empty and `inflight=0`. Then set `fb_rptr <= raddr` (one past the last byte read) and return to IDLE.
- `m_tdest` equals the latched `dest` for every beat of the frame.
- `m_tvalid` equals skid-buffer non-empty. The head pops on `m_tvalid & m_tready`.
- Only one frame is in flight at a time. A new sideband entry is not popped before DRAIN completes.

## Timing
- Reset values: `sb_ren=0`, `fb_ren=0`, `fb_raddr=0`, `fb_rptr=0`, `m_tvalid=0`, `m_tlast=0`, `m_tuser=0`, `m_tdata=0`, `m_tdest=0`; state IDLE, skid buffer empty.
- Latency: first `m_tvalid` arrives 4 cycles after `sb_empty` falls (IDLE pop, POP, read issue, data capture).
- Throughput: 1 byte per cycle with `m_tready` held high.
- Backpressure: `m_tdata`, `m_tlast`, `m_tuser` and `m_tdest` are held stable while `m_tvalid & ~m_tready`. No byte is lost or duplicated.
- `fb_rptr` changes exactly once per frame, in the DRAIN exit cycle. It never passes a byte not yet accepted on the output.
- Wrap-around: a frame crossing address 2^ADDR_WIDTH-1 to 0 is read contiguously. The wrap bit toggles.
- Single-byte frame (`tlast` on the first word): legal; one beat with `m_tlast=1`.
- `sb_empty` is ignored outside IDLE.
- Reset mid-frame: all state returns to reset values immediately. Any partial frame is abandoned with no `tlast` emitted.

## Structure
- `DEST_WIDTH` comes from `` `AXIS_DEST_WIDTH `` in `packet_filter.svh`.
- The sideband field offsets (dest LSB, pointer LSB) go into `filter_defs.svh`, shared with the sideband writer.
- The state enum stays local.
- Sub-module: `axis_skid_buffer`, a 2-entry output buffer with a `{tlast, tuser, tdata}` payload and count output.

## Test plan
- Sideband `{ptr=0x010, dest=2}`, buffer bytes 0xA0..0xA3 with `tlast` on 0xA3, `m_tready=1` → 4 beats, `tdest=2`, `tlast` on beat 4, `fb_rptr=0x014`.
- Same frame, `m_tready` toggling 1,0,0,1,… → identical byte sequence, outputs stable during stalls, no extra beats.
- Frame starting at `0x7FE`, 4 bytes → addresses 0x7FE, 0x7FF, 0x800, 0x801 read; `fb_rptr=0x802`.
- Two entries queued back-to-back (1 byte and 3 bytes) → second frame starts only after `fb_rptr` updates; `tdest` switches on the first beat of frame 2.
- No `tlast` in buffer, `MAX_FRAME_LEN=8` → 8 beats, beat 8 has `tlast=1` and `tuser=1`, `fb_rptr` advanced by 8.
- Assert `reset` during beat 2 of a 4-byte frame → all outputs at reset values the next cycle; after release, the next sideband entry streams correctly.
